// File: rtl/read_arbiter.sv
`default_nettype none
// ============================================================================
// read_arbiter : AR arbitration, slave decode and R-phase sequencing (2M x 2S)
// Revision     : 1.0
// ============================================================================
module read_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ARVALID_M0,
  input  logic        ARVALID_M1,
  input  logic [31:0] ARADDR_M1,
  input  logic        ARREADY_S0,
  input  logic        ARREADY_S1,
  output logic        ARVALID_S0,
  output logic        ARVALID_S1,
  output logic        ARREADY_M0,
  output logic        ARREADY_M1,
  output logic        ar_sel,
  input  logic        RVALID_S0,
  input  logic        RLAST_S0,
  input  logic        RVALID_S1,
  input  logic        RLAST_S1,
  input  logic        RREADY_M0,
  input  logic        RREADY_M1,
  output logic [2:0]  R_state,
  output logic        rd_timeout
);

  localparam logic [CNT_W-1:0] C_WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic [2:0]       r_grant_code, w_grant_code_nxt;
  logic             r_last_m1,    w_last_m1_nxt;
  logic [CNT_W-1:0] r_wd_cnt,     w_wd_cnt_nxt;
  logic             r_rd_timeout, w_rd_timeout_nxt;
  logic [2:0]       r_r_state,    w_r_state_nxt;
  logic             r_ar_sel,     w_ar_sel_nxt;

  logic w_gnt_m1, w_gnt_s1, w_in_addr;
  logic w_arvalid_m, w_arready_s, w_rvalid_s, w_rlast_s, w_rready_m;
  logic w_ar_hs, w_r_hs, w_any_req, w_win_m1;
  logic w_unused_addr;

  // Codes 2/3 both belong to M1; only code 3 targets S1.
  assign w_gnt_m1  = r_grant_code[1];
  assign w_gnt_s1  = (r_grant_code == 3'd3);
  assign w_in_addr = (r_state == S_ADDR);

  assign w_arvalid_m = w_gnt_m1 ? ARVALID_M1 : ARVALID_M0;
  assign w_arready_s = w_gnt_s1 ? ARREADY_S1 : ARREADY_S0;
  assign w_rvalid_s  = w_gnt_s1 ? RVALID_S1  : RVALID_S0;
  assign w_rlast_s   = w_gnt_s1 ? RLAST_S1   : RLAST_S0;
  assign w_rready_m  = w_gnt_m1 ? RREADY_M1  : RREADY_M0;

  assign w_ar_hs = w_arvalid_m & w_arready_s;
  assign w_r_hs  = w_rvalid_s & w_rready_m;

  assign w_any_req = ARVALID_M0 | ARVALID_M1;
  assign w_win_m1  = ARVALID_M1 & (~ARVALID_M0 | ~r_last_m1);

  assign w_unused_addr = ^{ARADDR_M1[31:17], ARADDR_M1[15:0]};

  assign ARVALID_S0 = w_in_addr & ~w_gnt_s1 & w_arvalid_m;
  assign ARVALID_S1 = w_in_addr &  w_gnt_s1 & w_arvalid_m;
  assign ARREADY_M0 = w_in_addr & ~w_gnt_m1 & w_arready_s;
  assign ARREADY_M1 = w_in_addr &  w_gnt_m1 & w_arready_s;

  assign ar_sel     = r_ar_sel;
  assign R_state    = r_r_state;
  assign rd_timeout = r_rd_timeout;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state      <= S_IDLE;
      r_grant_code <= 3'd0;
      r_last_m1    <= 1'b1;
      r_wd_cnt     <= '0;
      r_rd_timeout <= 1'b0;
      r_r_state    <= 3'd0;
      r_ar_sel     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_code <= w_grant_code_nxt;
      r_last_m1    <= w_last_m1_nxt;
      r_wd_cnt     <= w_wd_cnt_nxt;
      r_rd_timeout <= w_rd_timeout_nxt;
      r_r_state    <= w_r_state_nxt;
      r_ar_sel     <= w_ar_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_code_nxt = r_grant_code;
    w_last_m1_nxt    = r_last_m1;
    w_wd_cnt_nxt     = r_wd_cnt;
    w_rd_timeout_nxt = 1'b0;
    w_r_state_nxt    = r_r_state;
    w_ar_sel_nxt     = r_ar_sel;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          if (w_win_m1) begin
            w_grant_code_nxt = ARADDR_M1[16] ? 3'd3 : 3'd2;
          end else begin
            w_grant_code_nxt = 3'd1;
          end
          w_last_m1_nxt = w_win_m1;
          w_ar_sel_nxt  = w_win_m1;
          w_r_state_nxt = w_grant_code_nxt;
          w_state_nxt   = S_ADDR;
        end
      end

      S_ADDR: begin
        if (w_ar_hs) begin
          w_state_nxt  = S_DATA;
          w_wd_cnt_nxt = '0;
        end
      end

      S_DATA: begin
        // A beat on the terminal count still counts as progress.
        if (w_r_hs) begin
          w_wd_cnt_nxt = '0;
          if (w_rlast_s) begin
            w_state_nxt   = S_IDLE;
            w_r_state_nxt = 3'd0;
          end
        end else if (r_wd_cnt == C_WD_LAST) begin
          w_wd_cnt_nxt     = '0;
          w_rd_timeout_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
          w_r_state_nxt    = 3'd0;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_r_state_nxt = 3'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_read_arbiter.sv
`default_nettype none
// Bench for read_arbiter: directed vector table, then random traffic vs a reference model.
module tb_read_arbiter;

  localparam int TB_TO = 8;

  // Input vector bits: {rstn, m0v, m1v, a16, s0r, s1r, rv0, rl0, rv1, rl1, rr0, rr1}
  localparam logic [11:0] K_ON  = 12'h800, K_M0V = 12'h400, K_M1V = 12'h200, K_A16 = 12'h100;
  localparam logic [11:0] K_S0R = 12'h080, K_S1R = 12'h040, K_RV0 = 12'h020, K_RL0 = 12'h010;
  localparam logic [11:0] K_RV1 = 12'h008, K_RL1 = 12'h004, K_RR0 = 12'h002, K_RR1 = 12'h001;
  // Expected bits: {ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1, ar_sel, R_state[2:0], rd_timeout}
  localparam logic [8:0] X_AV0 = 9'h100, X_AV1 = 9'h080, X_AR0 = 9'h040, X_AR1 = 9'h020;
  localparam logic [8:0] X_SEL = 9'h010, X_R1 = 9'h002, X_R2 = 9'h004, X_R3 = 9'h006, X_TO = 9'h001;

  typedef struct {
    logic [11:0] in;
    logic [8:0]  ex;
    string       nm;
  } vec_t;

  logic        ACLK, ARESETn;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_S0, ARREADY_S1;
  logic [31:0] ARADDR_M1;
  logic        ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1, ar_sel;
  logic        RVALID_S0, RLAST_S0, RVALID_S1, RLAST_S1, RREADY_M0, RREADY_M1;
  logic [2:0]  R_state;
  logic        rd_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  // Reference model state: phase 0 idle, 1 address, 2 data
  int   m_ph, m_code, m_cnt;
  logic m_last, m_sel, m_to;

  read_arbiter #(.TIMEOUT(TB_TO), .CNT_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1), .ARADDR_M1(ARADDR_M1),
    .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1),
    .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1), .ar_sel(ar_sel),
    .RVALID_S0(RVALID_S0), .RLAST_S0(RLAST_S0), .RVALID_S1(RVALID_S1), .RLAST_S1(RLAST_S1),
    .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
    .R_state(R_state), .rd_timeout(rd_timeout)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  function automatic logic [8:0] outs();
    return {ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1, ar_sel, R_state, rd_timeout};
  endfunction

  task automatic drive(input logic [11:0] v);
    ARESETn    = v[11];
    ARVALID_M0 = v[10];
    ARVALID_M1 = v[9];
    ARADDR_M1  = v[8] ? 32'h0001_0000 : 32'h0000_0100;
    ARREADY_S0 = v[7];
    ARREADY_S1 = v[6];
    RVALID_S0  = v[5];
    RLAST_S0   = v[4];
    RVALID_S1  = v[3];
    RLAST_S1   = v[2];
    RREADY_M0  = v[1];
    RREADY_M1  = v[0];
  endtask

  task automatic check_cycle(input logic [8:0] ex, input string nm);
    @(negedge ACLK);
    n_tests++;
    if (outs() !== ex) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (av0 av1 ar0 ar1 sel Rst[3] to)", nm, outs(), ex);
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic add(input logic [11:0] in, input logic [8:0] ex, input string nm);
    vec_t v;
    v.in = in; v.ex = ex; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Expected outputs from the model for the current cycle's inputs.
  function automatic logic [8:0] model_out();
    logic [1:0] arv, ardy, av_s, ar_m;
    int mi, si;
    arv  = {ARVALID_M1, ARVALID_M0};
    ardy = {ARREADY_S1, ARREADY_S0};
    mi   = (m_code == 1) ? 0 : 1;
    si   = (m_code == 3) ? 1 : 0;
    av_s = 2'b00;
    ar_m = 2'b00;
    if (m_ph == 1) begin
      av_s[si] = arv[mi];
      ar_m[mi] = ardy[si];
    end
    return {av_s[0], av_s[1], ar_m[0], ar_m[1], m_sel,
            (m_ph != 0) ? 3'(m_code) : 3'd0, m_to};
  endfunction

  // Transaction-level rules applied at a clock edge.
  task automatic model_edge();
    logic [1:0] arv, ardy, rv, rl, rr;
    logic win_m1;
    int mi, si;
    arv  = {ARVALID_M1, ARVALID_M0};
    ardy = {ARREADY_S1, ARREADY_S0};
    rv   = {RVALID_S1, RVALID_S0};
    rl   = {RLAST_S1, RLAST_S0};
    rr   = {RREADY_M1, RREADY_M0};
    mi   = (m_code == 1) ? 0 : 1;
    si   = (m_code == 3) ? 1 : 0;
    if (!ARESETn) begin
      m_ph = 0; m_code = 0; m_cnt = 0; m_last = 1'b1; m_sel = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_ph == 0) begin
        if (arv != 2'b00) begin
          win_m1 = (arv == 2'b10) || (arv == 2'b11 && !m_last);
          m_code = win_m1 ? (ARADDR_M1[16] ? 3 : 2) : 1;
          m_last = win_m1;
          m_sel  = win_m1;
          m_ph   = 1;
        end
      end else if (m_ph == 1) begin
        if (arv[mi] && ardy[si]) begin
          m_ph = 2; m_cnt = 0;
        end
      end else begin
        if (rv[si] && rr[mi]) begin
          m_cnt = 0;
          if (rl[si]) m_ph = 0;
        end else if (m_cnt == TB_TO - 1) begin
          m_to = 1'b1; m_ph = 0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  initial begin
    drive(12'h000);
    @(posedge ACLK);
    #1;

    // M0 -> S0, ARREADY after 2 waits, 4-beat burst
    add(12'h000, 9'h000, "reset_state");
    add(K_ON|K_M0V, 9'h000, "m0_req_idle");
    add(K_ON|K_M0V, X_AV0|X_R1, "m0_addr_wait1");
    add(K_ON|K_M0V, X_AV0|X_R1, "m0_addr_wait2");
    add(K_ON|K_M0V|K_S0R, X_AV0|X_AR0|X_R1, "m0_addr_hs");
    for (int i = 0; i < 3; i++) add(K_ON|K_RV0|K_RR0, X_R1, "m0_beat");
    add(K_ON|K_RV0|K_RL0|K_RR0, X_R1, "m0_last_beat");
    add(K_ON, 9'h000, "m0_back_idle");
    // Ties: M0, M1(S1), M0
    add(12'h000, 9'h000, "tie_reset");
    add(K_ON|K_M0V|K_M1V|K_A16, 9'h000, "tie1_idle");
    add(K_ON|K_M0V|K_M1V|K_A16|K_S0R, X_AV0|X_AR0|X_R1, "tie1_m0_addr");
    add(K_ON|K_M1V|K_A16|K_RV0|K_RL0|K_RR0, X_R1, "tie1_m0_data");
    add(K_ON|K_M0V|K_M1V|K_A16, 9'h000, "tie2_idle");
    add(K_ON|K_M0V|K_M1V|K_A16|K_S1R, X_AV1|X_AR1|X_SEL|X_R3, "tie2_m1_addr");
    add(K_ON|K_M0V|K_RV1|K_RL1|K_RR1, X_SEL|X_R3, "tie2_m1_data");
    add(K_ON|K_M0V|K_M1V|K_A16, X_SEL, "tie3_idle_selhold");
    add(K_ON|K_M0V|K_M1V|K_A16|K_S0R, X_AV0|X_AR0|X_R1, "tie3_m0_addr");
    add(K_ON|K_RV0|K_RL0|K_RR0, X_R1, "tie3_m0_data");
    add(K_ON, 9'h000, "tie3_idle");
    // M1 -> S0, then watchdog with M0 waiting
    add(K_ON|K_M1V, 9'h000, "m1s0_idle");
    add(K_ON|K_M1V|K_M0V|K_S0R, X_AV0|X_AR1|X_SEL|X_R2, "m1s0_addr_hs");
    for (int i = 0; i < TB_TO; i++) add(K_ON|K_M0V|K_S0R, X_SEL|X_R2, "wd_wait_m0_blocked");
    add(K_ON|K_M0V, X_SEL|X_TO, "wd_timeout_pulse");
    add(K_ON|K_M0V, X_AV0|X_R1, "after_to_m0_addr");
    add(K_M0V, X_AV0|X_R1, "reset_in_addr");
    add(K_ON, 9'h000, "after_reset_addr");

    // Stall: RVALID without RREADY_M1 for 5 cycles, then 2 beats
    add(12'h000, 9'h000, "stall_reset");
    add(K_ON|K_M1V, 9'h000, "stall_idle");
    add(K_ON|K_M1V|K_S0R, X_AV0|X_AR1|X_SEL|X_R2, "stall_addr_hs");
    for (int i = 0; i < 5; i++) add(K_ON|K_RV0|K_RR0, X_SEL|X_R2, "stall_no_rready");
    add(K_ON|K_RV0|K_RR1, X_SEL|X_R2, "stall_beat1");
    add(K_ON|K_RV0|K_RL0|K_RR1, X_SEL|X_R2, "stall_beat2_last");
    for (int i = 0; i < TB_TO; i++) add(K_ON, X_SEL, "stall_idle_no_to");
    // Beat on the terminal count beats the watchdog
    add(K_ON|K_M0V, X_SEL, "tc_idle");
    add(K_ON|K_M0V|K_S0R, X_AV0|X_AR0|X_R1, "tc_addr_hs");
    for (int i = 0; i < TB_TO - 1; i++) add(K_ON, X_R1, "tc_count");
    add(K_ON|K_RV0|K_RR0, X_R1, "tc_beat_at_terminal");
    add(K_ON, X_R1, "tc_no_timeout");
    add(K_ON|K_RV0|K_RL0|K_RR0, X_R1, "tc_last");
    add(K_ON, 9'h000, "tc_idle_after");
    // Reset at beat 2 of 4, then tie goes to M0
    add(K_ON|K_M0V, 9'h000, "mid_idle");
    add(K_ON|K_M0V|K_S0R, X_AV0|X_AR0|X_R1, "mid_addr_hs");
    add(K_ON|K_RV0|K_RR0, X_R1, "mid_beat1");
    add(K_RV0|K_RR0, X_R1, "mid_beat2_reset");
    add(K_ON|K_M0V|K_M1V|K_A16, 9'h000, "mid_after_reset");
    add(K_ON|K_M0V|K_M1V|K_A16, X_AV0|X_R1, "mid_tie_m0");

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      check_cycle(tbl[i].ex, tbl[i].nm);
    end

    // Random traffic against the reference model
    drive(12'h000);
    @(posedge ACLK);
    #1;
    model_edge();
    for (int c = 0; c < 3000; c++) begin
      logic [11:0] v;
      v[11] = ($urandom_range(299) != 0);
      v[10] = $urandom_range(1);
      v[9]  = $urandom_range(1);
      v[8]  = 1'b0;
      v[7]  = $urandom_range(1);
      v[6]  = $urandom_range(1);
      v[5]  = ($urandom_range(9) < 6);
      v[4]  = ($urandom_range(9) < 3);
      v[3]  = ($urandom_range(9) < 6);
      v[2]  = ($urandom_range(9) < 3);
      v[1]  = ($urandom_range(9) < 6);
      v[0]  = ($urandom_range(9) < 6);
      drive(v);
      ARADDR_M1 = $urandom();
      @(negedge ACLK);
      n_tests++;
      if (outs() !== model_out()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %b expected %b", c, outs(), model_out());
      end
      model_edge();
      @(posedge ACLK);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/read_arbiter.md
# read_arbiter

Read-path arbiter and sequencer for the two-master/two-slave AXI interconnect. It arbitrates AR requests from M0 (instruction fetch) and M1 (data access), and decodes the target slave. It gates the AR handshake to one slave and drives the 3-bit `R_state` select consumed by the read data channel mux. The grant is held until the RLAST beat completes, or until a watchdog releases it.

## Interface
Parameters:
- `TIMEOUT`, default 1024: cycles without an R handshake in the data phase before the grant is forcibly released.
- `CNT_W`, default 11: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports (one clock; reset is synchronous and active-low):
- `ACLK` in 1: clock.
- `ARESETn` in 1: synchronous active-low reset.
- `ARVALID_M0` in 1: M0 read request; M0 always targets S0.
- `ARVALID_M1` in 1: M1 read request.
- `ARADDR_M1` in 32: M1 address; bit 16 = 1 selects S1, otherwise S0.
- `ARREADY_S0` in 1, `ARREADY_S1` in 1: slave address-ready.
- `ARVALID_S0` out 1, `ARVALID_S1` out 1: gated address-valid to the slaves.
- `ARREADY_M0` out 1, `ARREADY_M1` out 1: gated address-ready to the masters.
- `ar_sel` out 1: AR payload source for the address mux (0 = M0, 1 = M1).
- `RVALID_S0` in 1, `RLAST_S0` in 1, `RVALID_S1` in 1, `RLAST_S1` in 1: slave read-data status.
- `RREADY_M0` in 1, `RREADY_M1` in 1: master read-ready.
- `R_state` out 3: 0 = IDLE, 1 = M0↔S0, 2 = M1↔S0, 3 = M1↔S1.
- `rd_timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states:
  - IDLE
  - ADDR: AR handshake pending.
  - DATA: R beats in flight.
- Registers: `state`, `grant_code` (3b), `last_m1` (1b), `wd_cnt` (CNT_W).
- IDLE, arbitration:
  - Only M0 requests → M0 wins.
  - Only M1 requests → M1 wins.
  - Both request → grant the master that did not win last (`last_m1`=1 → M0, else M1).
- IDLE, on a grant:
  - Latch `grant_code`: M0 → 1; M1 → 2 if `ARADDR_M1[16]`=0, else 3.
  - Update `last_m1`.
  - Go to ADDR.
- ADDR:
  - `ARVALID_Sx` = `ARVALID_Mgranted`, routed to the decoded slave only.
  - `ARREADY_Mgranted` = `ARREADY_Sx`.
  - All other AR outputs are 0.
  - On `ARVALID_Sx & ARREADY_Sx` → DATA, clear `wd_cnt`.
- DATA:
  - AR outputs all 0; new requests wait.
  - R handshake = `RVALID_Sx & RREADY_Mgranted`.
  - Each handshake clears `wd_cnt`; otherwise `wd_cnt` increments.
  - Handshake with `RLAST_Sx`=1 → IDLE.
  - `wd_cnt` = TIMEOUT-1 with no handshake → pulse `rd_timeout`, go to IDLE.
- `R_state` = `grant_code` in ADDR and DATA; 0 in IDLE. It is registered with no combinational path from inputs.
- `ar_sel` = 1 iff `grant_code` ∈ {2,3}; it holds its last value in IDLE.
- The granted master may drop ARVALID in ADDR, which violates AXI. The FSM stays in ADDR until the handshake; there is no recovery path.

## Timing
- Reset (ARESETn=0 at a rising edge):
  - `state`=IDLE, `R_state`=0, `grant_code`=0, `ar_sel`=0.
  - `last_m1`=1, so M0 wins the first tie.
  - `wd_cnt`=0, `rd_timeout`=0, all ARVALID_S*/ARREADY_M* = 0.
- Reset mid-burst: all of the above takes effect at that edge; the outstanding transaction is abandoned.
- Arbitration latency:
  - Request sampled in IDLE at edge N → ADDR and `R_state` valid after edge N.
  - Gated ARVALID is visible in cycle N+1.
- An AR handshake in the first ADDR cycle puts the FSM in DATA at edge N+2.
- Back-to-back transactions:
  - Last R beat at edge K → IDLE after K; the next grant happens at K+1.
  - Minimum one IDLE cycle between transactions, during which `R_state`=0.
- Single-beat burst (RLAST on the first beat) → IDLE after that beat's edge.
- Simultaneous R handshake and watchdog terminal count: the handshake wins. No `rd_timeout`; the counter clears or the FSM exits on RLAST.
- `rd_timeout` is high for exactly the cycle after the terminal edge.

## Test plan
- Reset, then M0 issues AR to S0 (ARREADY_S0 after 2 cycles) with a 4-beat burst, RLAST on the 4th → `R_state`=1 from ADDR entry through the 4th beat, then 0; ARVALID_S1 never asserted.
- M0 and M1 (ARADDR_M1=0x0001_0000) request in the same cycle, single beats, requests held → first grant M0 (`R_state`=1), then M1 (`R_state`=3); a repeated tie alternates M0, M1, M0.
- M1 reads 0x0000_0100 → `R_state`=2, `ar_sel`=1, only ARVALID_S0 gated high; M0 requesting during DATA gets ARREADY_M0=0 until M1's RLAST completes.
- Slave holds RVALID=1 with RREADY_M1=0 for 5 cycles, then RREADY_M1=1 on a 2-beat burst → `wd_cnt` never fires; exits after 2 beats.
- TIMEOUT=8, slave never asserts RVALID after the AR handshake → `rd_timeout` pulses once 8 cycles after DATA entry; `R_state` returns to 0 the same cycle.
- ARESETn=0 mid-burst at beat 2 of 4 → next cycle `R_state`=0, all AR outputs 0; after release, an M0 request wins the first tie against M1.
